// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide unit owning the HI/LO registers
module muldiv_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        cancel,
    output logic        op_ready,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_hi;
    logic [31:0] r_lo;
    // r_a holds the multiplicand, or the dividend magnitude that is shifted
    // left one bit per DIV cycle while quotient bits enter at the bottom.
    logic [31:0] r_a;
    // r_b holds the multiplier, or the divisor magnitude.
    logic [31:0] r_b;
    logic [31:0] r_rem;
    logic [4:0]  r_cnt;
    logic        r_signed;
    logic        r_sign_a;
    logic        r_sign_b;

    logic        w_accept;
    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;
    logic [63:0] w_prod;
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_qbit;
    logic [31:0] w_rem_next;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;
    logic        w_op_signed;
    logic        w_neg_a;
    logic        w_neg_b;

    assign op_ready = (r_state == S_IDLE) & resetn;
    assign busy     = (r_state != S_IDLE);
    assign hi       = r_hi;
    assign lo       = r_lo;

    assign w_accept = op_valid & op_ready & ~cancel;

    // MULT/MULTU share one 64-bit multiplier: sign-extend only for MULT, the
    // low 64 bits of the product are then correct in both cases.
    assign w_ext_a = {{32{r_signed & r_a[31]}}, r_a};
    assign w_ext_b = {{32{r_signed & r_b[31]}}, r_b};
    assign w_prod  = w_ext_a * w_ext_b;

    // One restoring step: bring the next dividend bit into the partial
    // remainder and keep the subtraction only if it did not go negative.
    assign w_shift    = {r_rem, r_a[31]};
    assign w_diff     = w_shift - {1'b0, r_b};
    assign w_qbit     = ~w_diff[32];
    assign w_rem_next = w_qbit ? w_diff[31:0] : w_shift[31:0];

    // Quotient takes sign(a)^sign(b), remainder takes sign(a). A zero divisor
    // leaves the remainder equal to |a|, so re-signing yields src_a exactly.
    assign w_quo_fix = (r_sign_a ^ r_sign_b) ? (32'd0 - r_a) : r_a;
    assign w_rem_fix = r_sign_a ? (32'd0 - r_rem) : r_rem;

    assign w_op_signed = (op == OP_DIV);
    assign w_neg_a     = w_op_signed & src_a[31];
    assign w_neg_b     = w_op_signed & src_b[31];

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; cancel drops any in-flight op back to IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (op)
                        OP_MULT, OP_MULTU: w_next = S_MUL;
                        OP_DIV, OP_DIVU:   w_next = S_DIV;
                        default:           w_next = S_IDLE;
                    endcase
                end
            end
            S_MUL: w_next = S_IDLE;
            S_DIV: begin
                if (cancel) begin
                    w_next = S_IDLE;
                end else if (r_cnt == 5'd31) begin
                    w_next = S_FIX;
                end
            end
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: operand capture, division iteration and HI/LO writes.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_rem    <= 32'd0;
            r_cnt    <= 5'd0;
            r_signed <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        case (op)
                            OP_MTHI: r_hi <= src_a;
                            OP_MTLO: r_lo <= src_a;
                            OP_MULT, OP_MULTU: begin
                                r_a      <= src_a;
                                r_b      <= src_b;
                                r_signed <= (op == OP_MULT);
                            end
                            OP_DIV, OP_DIVU: begin
                                r_a      <= w_neg_a ? (32'd0 - src_a) : src_a;
                                r_b      <= w_neg_b ? (32'd0 - src_b) : src_b;
                                r_sign_a <= w_neg_a;
                                r_sign_b <= w_neg_b;
                                r_signed <= w_op_signed;
                                r_rem    <= 32'd0;
                                r_cnt    <= 5'd0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (!cancel) begin
                        r_hi <= w_prod[63:32];
                        r_lo <= w_prod[31:0];
                    end
                end
                S_DIV: begin
                    if (!cancel) begin
                        r_rem <= w_rem_next;
                        r_a   <= {r_a[30:0], w_qbit};
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                S_FIX: begin
                    if (!cancel) begin
                        r_hi <= w_rem_fix;
                        r_lo <= (r_b == 32'd0) ? 32'hFFFF_FFFF : w_quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized self-checking bench for muldiv_unit
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        op_ready;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk      (clk),
        .resetn   (resetn),
        .op_valid (op_valid),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .cancel   (cancel),
        .op_ready (op_ready),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo)
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Architectural result {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        int              ia;
        int              ib;
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        longint          sp;
        longint unsigned up;
        int              q;
        int              r;
        ia = a;
        ib = b;
        sa = ia;
        sb = ib;
        ua = a;
        ub = b;
        case (o)
            3'd0: begin
                sp = sa * sb;
                return sp;
            end
            3'd1: begin
                up = ua * ub;
                return up;
            end
            3'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = ia / ib;
                r = ia % ib;
                return {r, q};
            end
            3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return {exp_hi, exp_lo};
        endcase
    endfunction

    task automatic run_mul(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        r = ref_model(o, a, b);
        op_valid = 1'b1; op = o; src_a = a; src_b = b;
        step();
        op_valid = 1'b0; src_a = $urandom; src_b = $urandom;
        checks++;
        if (busy !== 1'b1 || op_ready !== 1'b0) begin
            errors++;
            $display("FAIL mul_cycle1 busy=%b ready=%b required busy=1 ready=0", busy, op_ready);
        end
        step();
        checks++;
        if (busy !== 1'b0 || op_ready !== 1'b1) begin
            errors++;
            $display("FAIL mul_cycle2 busy=%b ready=%b required busy=0 ready=1", busy, op_ready);
        end
        checks++;
        if ({hi, lo} !== r) begin
            errors++;
            $display("FAIL mul_result op=%0d a=%h b=%h got %h_%h required %h_%h",
                     o, a, b, hi, lo, r[63:32], r[31:0]);
        end
        {exp_hi, exp_lo} = r;
    endtask

    task automatic run_div(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        logic        bad;
        r = ref_model(o, a, b);
        bad = 1'b0;
        op_valid = 1'b1; op = o; src_a = a; src_b = b;
        step();
        op_valid = 1'b0; src_a = $urandom; src_b = $urandom;
        for (int c = 1; c <= 33; c++) begin
            if (busy !== 1'b1 || op_ready !== 1'b0 || hi !== exp_hi || lo !== exp_lo) bad = 1'b1;
            step();
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL div_inflight op=%0d a=%h b=%h busy or hi/lo wrong during cycles 1-33", o, a, b);
        end
        checks++;
        if (busy !== 1'b0 || op_ready !== 1'b1 || {hi, lo} !== r) begin
            errors++;
            $display("FAIL div_result op=%0d a=%h b=%h got busy=%b ready=%b %h_%h required 0 1 %h_%h",
                     o, a, b, busy, op_ready, hi, lo, r[63:32], r[31:0]);
        end
        {exp_hi, exp_lo} = r;
    endtask

    task automatic test_reset();
        resetn = 1'b0; op_valid = 1'b1; op = 3'd4; src_a = 32'hA5A5_A5A5; src_b = 32'd0; cancel = 1'b0;
        step();
        step();
        checks++;
        if (op_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl ready=%b busy=%b required 0 0", op_ready, busy);
        end
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_hilo got %h_%h required 0_0", hi, lo);
        end
        op_valid = 1'b0;
        resetn = 1'b1;
        #1;
        checks++;
        if (op_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release ready=%b required 1", op_ready);
        end
        exp_hi = 32'd0; exp_lo = 32'd0;
    endtask

    task automatic test_mult();
        run_mul(3'd0, 32'hFFFF_FFFD, 32'd7);
        run_mul(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_mul(3'd0, 32'h8000_0000, 32'h8000_0000);
        for (int i = 0; i < 16; i++) begin
            run_mul(3'($urandom_range(0, 1)), $urandom, $urandom);
        end
    endtask

    task automatic test_div();
        logic [31:0] b;
        run_div(3'd2, 32'hFFFF_FFF9, 32'd2);
        run_div(3'd3, 32'hFFFF_FFFF, 32'h10);
        run_div(3'd3, 32'd5, 32'd0);
        run_div(3'd2, 32'hFFFF_FFF9, 32'd0);
        run_div(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_div(3'd2, 32'd100, 32'hFFFF_FFF9);
        for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 2))
                0:       b = $urandom_range(1, 20);
                1:       b = 32'd0 - $urandom_range(1, 20);
                default: b = $urandom;
            endcase
            run_div(3'($urandom_range(2, 3)), $urandom, b);
        end
    endtask

    task automatic test_back_to_back();
        op_valid = 1'b1; op = 3'd4; src_a = 32'h1111_1111;
        step();
        checks++;
        if (hi !== 32'h1111_1111 || op_ready !== 1'b1) begin
            errors++;
            $display("FAIL mthi_b2b hi=%h ready=%b required 11111111 1", hi, op_ready);
        end
        op = 3'd5; src_a = 32'h2222_2222;
        step();
        op_valid = 1'b0;
        checks++;
        if (hi !== 32'h1111_1111 || lo !== 32'h2222_2222) begin
            errors++;
            $display("FAIL mtlo_b2b got %h_%h required 11111111_22222222", hi, lo);
        end
        exp_hi = 32'h1111_1111; exp_lo = 32'h2222_2222;
    endtask

    task automatic test_cancel();
        op_valid = 1'b1; op = 3'd2; src_a = $urandom; src_b = $urandom_range(1, 99);
        step();
        op_valid = 1'b0;
        repeat (9) step();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        checks++;
        if (op_ready !== 1'b1 || busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
            errors++;
            $display("FAIL cancel_div ready=%b busy=%b got %h_%h required 1 0 %h_%h",
                     op_ready, busy, hi, lo, exp_hi, exp_lo);
        end
        op_valid = 1'b1; op = 3'd3; src_a = $urandom; src_b = $urandom_range(1, 99);
        step();
        op_valid = 1'b0;
        repeat (32) step();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        checks++;
        if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
            errors++;
            $display("FAIL cancel_fix busy=%b got %h_%h required 0 %h_%h", busy, hi, lo, exp_hi, exp_lo);
        end
        op_valid = 1'b1; op = 3'd1; src_a = 32'h0001_0000; src_b = 32'h0001_0000;
        step();
        op_valid = 1'b0;
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        checks++;
        if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
            errors++;
            $display("FAIL cancel_mul busy=%b got %h_%h required 0 %h_%h", busy, hi, lo, exp_hi, exp_lo);
        end
        op_valid = 1'b1; op = 3'd4; src_a = 32'hDEAD_BEEF; cancel = 1'b1;
        step();
        op = 3'd0;
        step();
        op_valid = 1'b0; cancel = 1'b0;
        checks++;
        if (hi !== exp_hi || busy !== 1'b0) begin
            errors++;
            $display("FAIL cancel_same_cycle hi=%h busy=%b required %h 0", hi, busy, exp_hi);
        end
    endtask

    task automatic test_ignore_busy();
        op_valid = 1'b1; op = 3'd3; src_a = $urandom; src_b = $urandom_range(1, 99);
        step();
        op = 3'd5; src_a = 32'hCAFE_F00D;
        repeat (3) step();
        op_valid = 1'b0;
        checks++;
        if (lo !== exp_lo || busy !== 1'b1) begin
            errors++;
            $display("FAIL ignore_busy lo=%h busy=%b required %h 1", lo, busy, exp_lo);
        end
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        checks++;
        if (lo !== exp_lo || op_ready !== 1'b1) begin
            errors++;
            $display("FAIL ignore_busy_after lo=%h ready=%b required %h 1", lo, op_ready, exp_lo);
        end
    endtask

    task automatic test_reset_mid();
        op_valid = 1'b1; op = 3'd3; src_a = 32'hFFFF_0000; src_b = 32'd3;
        step();
        op_valid = 1'b0;
        repeat (19) step();
        resetn = 1'b0;
        step();
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || op_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got %h_%h busy=%b ready=%b required 0_0 0 0", hi, lo, busy, op_ready);
        end
        step();
        checks++;
        if (op_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold ready=%b required 0", op_ready);
        end
        resetn = 1'b1;
        #1;
        checks++;
        if (op_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_release ready=%b busy=%b required 1 0", op_ready, busy);
        end
        exp_hi = 32'd0; exp_lo = 32'd0;
        run_mul(3'd0, $urandom, $urandom);
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_back_to_back();
        test_cancel();
        test_ignore_busy();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
